// File: rtl/sdram_stream_writer.sv
// -----------------------------------------------------------------------------
// sdram_stream_writer
//
// Packs an incoming word stream into fixed-length SDRAM write bursts. Words are
// collected in a BURST_LENGTH-deep buffer; once the buffer is full (or a word
// flagged s_last arrives) one address beat and exactly BURST_LENGTH data beats
// are handed to the SDRAM driver's writer port. Short frame tails are padded
// with zero words so every burst has the same shape. Write addresses advance
// through a circular region and snap back to BASE_ADDR at the end of a frame.
//
// Ports
//   clk_axi       single clock
//   rstn_axi      synchronous, active-low reset
//   s_valid       input stream word valid
//   s_ready       input stream word accepted when s_valid && s_ready
//   s_data        input stream word
//   s_last        marks the final word of a frame
//   writer_valid  request toward the SDRAM driver writer port
//   writer_ready  driver accepts the current address or data beat
//   writer_addr   burst start address (meaningful in CMD)
//   writer_data   burst data beat (meaningful in DATA, zero elsewhere)
//   busy_o        low only while filling with an empty buffer
//   frame_done_o  one-cycle pulse after the burst carrying s_last completes
//   burst_cnt_o   number of bursts issued, wrapping modulo 2^16
// -----------------------------------------------------------------------------
module sdram_stream_writer #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_LENGTH = 8,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 480000
) (
    input  logic                  clk_axi,
    input  logic                  rstn_axi,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  writer_valid,
    input  logic                  writer_ready,
    output logic [ADDR_WIDTH-1:0] writer_addr,
    output logic [DATA_WIDTH-1:0] writer_data,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [15:0]           burst_cnt_o
);

    localparam int IDX_W = $clog2(BURST_LENGTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] END_A    = ADDR_WIDTH'(BASE_ADDR + REGION_WORDS);
    localparam logic [ADDR_WIDTH-1:0] STEP_A   = ADDR_WIDTH'(BURST_LENGTH);
    localparam logic [CNT_W-1:0]      FULL_M1  = CNT_W'(BURST_LENGTH - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        FILL,
        CMD,
        DATA
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       fill_cnt;
    logic [IDX_W-1:0]       beat_idx;
    logic                   last_flag;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [DATA_WIDTH-1:0]  beat_buf [BURST_LENGTH];

    logic                   s_accept;
    logic                   burst_end;

    assign s_accept    = s_valid && s_ready;
    assign burst_end   = (state == DATA) && writer_ready && (beat_idx == LAST_IDX);
    assign writer_addr = wr_ptr;

    // Stream words land in the buffer slot selected by fill_cnt. s_ready is
    // only high while filling, so the buffer is frozen during CMD and DATA.
    always_ff @(posedge clk_axi) begin
        if (rstn_axi && s_accept) begin
            beat_buf[fill_cnt[IDX_W-1:0]] <= s_data;
        end
    end

    // Slots beyond what was filled are sent as zero padding so a frame tail
    // still produces a full-length burst.
    always_comb begin
        writer_data = '0;
        if ((state == DATA) && ({1'b0, beat_idx} < fill_cnt)) begin
            writer_data = beat_buf[beat_idx];
        end
    end

    // Burst FSM. The handshake-facing outputs are registered and updated on
    // the same edge as the state change, so writer_valid rises the cycle
    // right after the closing input word is accepted. writer_valid is high
    // throughout CMD and DATA, so writer_ready alone completes a beat there.
    always_ff @(posedge clk_axi) begin
        if (!rstn_axi) begin
            state        <= FILL;
            fill_cnt     <= '0;
            beat_idx     <= '0;
            last_flag    <= 1'b0;
            wr_ptr       <= BASE_A;
            s_ready      <= 1'b1;
            writer_valid <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            burst_cnt_o  <= '0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                FILL: begin
                    if (s_accept) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                        busy_o   <= 1'b1;
                        if ((fill_cnt == FULL_M1) || s_last) begin
                            state        <= CMD;
                            last_flag    <= s_last;
                            s_ready      <= 1'b0;
                            writer_valid <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (writer_ready) begin
                        state    <= DATA;
                        beat_idx <= '0;
                    end
                end
                DATA: begin
                    if (writer_ready) begin
                        beat_idx <= beat_idx + IDX_W'(1);
                    end
                    if (burst_end) begin
                        state        <= FILL;
                        fill_cnt     <= '0;
                        burst_cnt_o  <= burst_cnt_o + 16'd1;
                        s_ready      <= 1'b1;
                        writer_valid <= 1'b0;
                        busy_o       <= 1'b0;
                        last_flag    <= 1'b0;
                        frame_done_o <= last_flag;
                        // A finished frame restarts at the region base;
                        // otherwise step forward and wrap at the region end.
                        if (last_flag) begin
                            wr_ptr <= BASE_A;
                        end else if (wr_ptr + STEP_A == END_A) begin
                            wr_ptr <= BASE_A;
                        end else begin
                            wr_ptr <= wr_ptr + STEP_A;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_sdram_stream_writer
//
// Scoreboard bench for sdram_stream_writer (BL=8, small 16-word region at a
// non-zero base so address wrap and base reload are both visible). The stream
// driver feeds a reference packer that pushes the expected address/data beats
// of each burst into a queue; a negedge monitor pops and compares every beat
// the DUT hands over, and also tracks burst count, frame_done pulses and
// output stability while writer_ready is held low.
// -----------------------------------------------------------------------------
module tb_sdram_stream_writer;

    localparam int AW     = 24;
    localparam int DW     = 16;
    localparam int BL     = 8;
    localparam int BASE   = 64;
    localparam int REGION = 16;

    typedef struct {
        bit          isAddr;
        logic [31:0] val;
        bit          lastBeat;
        bit          frame;
    } sbEntry_t;

    logic          clk_axi = 1'b0;
    logic          rstn_axi = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          writer_valid;
    logic          writer_ready = 1'b1;
    logic [AW-1:0] writer_addr;
    logic [DW-1:0] writer_data;
    logic          busy_o;
    logic          frame_done_o;
    logic [15:0]   burst_cnt_o;

    sbEntry_t      sbq[$];
    logic [DW-1:0] pending[$];
    int            modelPtr = BASE;
    int            numChecks = 0;
    int            numFails = 0;
    int            readyMode = 0;
    int            cyc = 0;
    int            expBursts = 0;
    int            dataIdx = 0;
    bit            pendingDone = 0;
    bit            prevStall = 0;
    logic [AW-1:0] prevAddr;
    logic [DW-1:0] prevData;

    sdram_stream_writer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BURST_LENGTH(BL),
        .BASE_ADDR   (BASE),
        .REGION_WORDS(REGION)
    ) dut (
        .clk_axi     (clk_axi),
        .rstn_axi    (rstn_axi),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .writer_valid(writer_valid),
        .writer_ready(writer_ready),
        .writer_addr (writer_addr),
        .writer_data (writer_data),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .burst_cnt_o (burst_cnt_o)
    );

    // 100 MHz clock
    always #5 clk_axi = ~clk_axi;

    // Every comparison in the bench funnels through here so the counters in
    // the summary line are the ones that actually moved.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference packer: turns the words collected so far into the expected
    // address beat plus BL data beats (zero padded) and advances the pointer.
    task automatic modelBurst(input bit frame);
        sbEntry_t e;
        e = '{isAddr: 1'b1, val: 32'(modelPtr), lastBeat: 1'b0, frame: 1'b0};
        sbq.push_back(e);
        for (int i = 0; i < BL; i++) begin
            e.isAddr   = 1'b0;
            e.val      = (i < pending.size()) ? 32'(pending[i]) : 32'h0;
            e.lastBeat = (i == BL - 1);
            e.frame    = (i == BL - 1) && frame;
            sbq.push_back(e);
        end
        if (frame || (modelPtr + BL == BASE + REGION)) begin
            modelPtr = BASE;
        end else begin
            modelPtr = modelPtr + BL;
        end
        pending.delete();
    endtask

    // Offers one word with s_valid held high until the DUT takes it, then
    // feeds the reference packer. Called at posedge+1, returns at posedge+1.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
        bit accepted;
        accepted = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk_axi);
            accepted = s_ready;
            @(posedge clk_axi);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!accepted) begin
            checkOutput("s_ready_timeout", 32'd0, 32'd1);
        end else begin
            pending.push_back(d);
            if (last || pending.size() == BL) begin
                modelBurst(last);
            end
        end
    endtask

    // Waits until every expected beat has been consumed and the DUT is idle.
    task automatic waitIdle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk_axi);
            idle = (sbq.size() == 0) && !writer_valid && !busy_o;
        end
        if (!idle) begin
            checkOutput("drain_timeout", 32'd0, 32'd1);
        end
        @(posedge clk_axi);
        #1;
    endtask

    // writer_ready pattern: always ready, ready one cycle in three, or random.
    always @(posedge clk_axi) begin
        cyc++;
        #1;
        case (readyMode)
            0:       writer_ready = 1'b1;
            1:       writer_ready = (cyc % 3 == 0);
            default: writer_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares each completed beat against the scoreboard, checks
    // burst count and frame_done timing every cycle, and verifies that the
    // request stays frozen while the driver stalls.
    always @(negedge clk_axi) begin
        sbEntry_t e;
        if (!rstn_axi) begin
            sbq.delete();
            expBursts   = 0;
            dataIdx     = 0;
            pendingDone = 0;
            prevStall   = 0;
        end else begin
            checkOutput("frame_done", 32'(frame_done_o), 32'(pendingDone));
            checkOutput("burst_cnt", 32'(burst_cnt_o), 32'(expBursts & 16'hFFFF));
            pendingDone = 0;
            if (writer_valid) begin
                if (prevStall) begin
                    checkOutput("stall_addr", 32'(writer_addr), 32'(prevAddr));
                    checkOutput("stall_data", 32'(writer_data), 32'(prevData));
                end
                if (sbq.size() == 0) begin
                    checkOutput("spurious_beat", 32'd1, 32'd0);
                    prevStall = 0;
                end else if (writer_ready) begin
                    e = sbq.pop_front();
                    if (e.isAddr) begin
                        checkOutput("addr_beat", 32'(writer_addr), e.val);
                    end else begin
                        checkOutput("data_beat", 32'(writer_data), e.val);
                        dataIdx++;
                    end
                    if (e.lastBeat) begin
                        expBursts++;
                        pendingDone = e.frame;
                        dataIdx     = 0;
                    end
                    prevStall = 0;
                end else begin
                    prevStall = 1;
                    prevAddr  = writer_addr;
                    prevData  = writer_data;
                end
            end else begin
                prevStall = 0;
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk_axi);
        @(negedge clk_axi);
        checkOutput("rst_writer_valid", 32'(writer_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_addr", 32'(writer_addr), 32'(BASE));
        checkOutput("rst_data", 32'(writer_data), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done_o), 32'd0);
        checkOutput("rst_burst_cnt", 32'(burst_cnt_o), 32'd0);
        @(posedge clk_axi);
        #1;
        rstn_axi = 1'b1;
        @(negedge clk_axi);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk_axi);
        #1;

        // Full burst 1..8 with the driver always ready
        readyMode = 0;
        applyStimulus(16'h0001, 1'b0);
        checkOutput("busy_after_one", 32'(busy_o), 32'd1);
        checkOutput("no_early_request", 32'(writer_valid), 32'd0);
        for (int i = 2; i <= BL; i++) begin
            applyStimulus(16'(i), 1'b0);
        end
        checkOutput("latency_valid", 32'(writer_valid), 32'd1);
        checkOutput("latency_s_ready", 32'(s_ready), 32'd0);
        waitIdle(100);
        checkOutput("next_addr", 32'(writer_addr), 32'(BASE + BL));
        checkOutput("burst_cnt_one", 32'(burst_cnt_o), 32'd1);

        // Short frame: three words, zero padded, frame_done and base reload
        applyStimulus(16'hAAAA, 1'b0);
        applyStimulus(16'hBBBB, 1'b0);
        applyStimulus(16'hCCCC, 1'b1);
        waitIdle(100);
        checkOutput("frame_base_addr", 32'(writer_addr), 32'(BASE));

        // Three full bursts through a stalling driver: addresses wrap
        readyMode = 1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < BL; i++) begin
                applyStimulus(16'($urandom), 1'b0);
            end
        end
        waitIdle(400);
        checkOutput("wrap_addr", 32'(writer_addr), 32'(modelPtr));

        // Random frame lengths against a random driver
        readyMode = 2;
        for (int f = 0; f < 4; f++) begin
            int len;
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                applyStimulus(16'($urandom), i == len - 1);
            end
        end
        waitIdle(600);

        // Reset while the burst is on data beat 4
        readyMode = 0;
        for (int i = 0; i < BL; i++) begin
            applyStimulus(16'(16'h0200 + i), 1'b0);
        end
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 40 && !hit; i++) begin
                if (dataIdx == 4) begin
                    hit = 1'b1;
                end else begin
                    @(posedge clk_axi);
                    #1;
                end
            end
            checkOutput("reached_beat4", 32'(hit), 32'd1);
        end
        rstn_axi = 1'b0;
        @(posedge clk_axi);
        @(negedge clk_axi);
        checkOutput("midrst_valid", 32'(writer_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_burst_cnt", 32'(burst_cnt_o), 32'd0);
        @(posedge clk_axi);
        #1;
        rstn_axi = 1'b1;
        modelPtr = BASE;
        pending.delete();
        @(negedge clk_axi);
        checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);
        checkOutput("post_rst_addr", 32'(writer_addr), 32'(BASE));
        @(posedge clk_axi);
        #1;
        for (int i = 0; i < BL; i++) begin
            applyStimulus(16'(16'h0300 + i), 1'b0);
        end
        waitIdle(100);

        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 numChecks, numFails);
        $finish;
    end

endmodule
